// File: rtl/bram_sched_pkg.sv
// Shared types and sizing helpers for the BRAM port scheduler.
// The clear counter covers half the depth because both ports write during a sweep.
package bram_sched_pkg;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } sched_state_t;

    // Depth=2 still needs a one-bit counter even though it never advances.
    function automatic int cnt_width(input int depth);
        int w;
        w = $clog2(depth) - 1;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bram_port_scheduler.sv
// Shares one read-first dual-port BRAM between a lookup reader (port 0) and an
// update writer (port 1), with a two-port clear sweep and fair collision arbitration.
module bram_port_scheduler
    import bram_sched_pkg::*;
#(
    parameter int Depth = 512,
    parameter int Width = 36
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     init_start,
    output logic                     init_busy,
    output logic                     clear_done,

    input  logic                     rd_valid,
    output logic                     rd_ready,
    input  logic [$clog2(Depth)-1:0] rd_addr,
    output logic                     rd_resp_valid,
    output logic [Width-1:0]         rd_resp_data,

    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [$clog2(Depth)-1:0] wr_addr,
    input  logic [Width-1:0]         wr_data,

    output logic                     bram_en_0,
    output logic                     bram_wen_0,
    output logic [$clog2(Depth)-1:0] bram_addr_0,
    output logic [Width-1:0]         bram_din_0,
    input  logic [Width-1:0]         bram_dout_0,

    output logic                     bram_en_1,
    output logic                     bram_wen_1,
    output logic [$clog2(Depth)-1:0] bram_addr_1,
    output logic [Width-1:0]         bram_din_1
);

    localparam int AW = $clog2(Depth);
    localparam int CW = cnt_width(Depth);
    localparam logic [CW-1:0] CNT_LAST = CW'(Depth / 2 - 1);

    sched_state_t  state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          rd_prio, rd_prio_d;
    logic          conflict;
    logic          rd_fire;
    logic [CW:0]   clr_addr_0, clr_addr_1;

    // Even/odd address pair cleared in the current sweep cycle.
    assign clr_addr_0 = {cnt, 1'b0};
    assign clr_addr_1 = {cnt, 1'b1};

    assign conflict     = rd_valid & wr_valid & (rd_addr == wr_addr);
    assign rd_fire      = rd_valid & rd_ready;
    assign rd_resp_data = bram_dout_0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_CLEAR;
            cnt           <= '0;
            rd_prio       <= 1'b0;
            rd_resp_valid <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            rd_prio       <= rd_prio_d;
            rd_resp_valid <= rd_fire;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        rd_prio_d   = 1'b0;
        init_busy   = 1'b0;
        clear_done  = 1'b0;
        rd_ready    = 1'b0;
        wr_ready    = 1'b0;
        bram_en_0   = 1'b0;
        bram_wen_0  = 1'b0;
        bram_addr_0 = rd_addr;
        bram_din_0  = '0;
        bram_en_1   = 1'b0;
        bram_wen_1  = 1'b0;
        bram_addr_1 = wr_addr;
        bram_din_1  = wr_data;

        case (state)
            S_CLEAR: begin
                init_busy   = 1'b1;
                clear_done  = (cnt == CNT_LAST);
                bram_en_0   = 1'b1;
                bram_wen_0  = 1'b1;
                bram_addr_0 = clr_addr_0[AW-1:0];
                bram_en_1   = 1'b1;
                bram_wen_1  = 1'b1;
                bram_addr_1 = clr_addr_1[AW-1:0];
                bram_din_1  = '0;
                cnt_d       = cnt + CW'(1);
                if (cnt == CNT_LAST) begin
                    state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                // On a same-address collision, rd_prio hands the win to the read
                // only if it lost last cycle, so the two sides alternate.
                rd_ready   = ~(conflict & ~rd_prio);
                wr_ready   = ~(conflict & rd_prio);
                rd_prio_d  = conflict & ~rd_prio;
                bram_en_0  = rd_valid & rd_ready;
                bram_en_1  = wr_valid & wr_ready;
                bram_wen_1 = wr_valid & wr_ready;
                if (init_start) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = S_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_bram_port_scheduler.sv
// Scoreboard bench for bram_port_scheduler with a behavioural BRAM and reference model.
module tb_bram_port_scheduler;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;
    localparam int HALF  = DEPTH / 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       init_start = 1'b0;
    logic       init_busy, clear_done;
    logic       rd_valid = 1'b0;
    logic       rd_ready;
    logic [2:0] rd_addr = '0;
    logic       rd_resp_valid;
    logic [7:0] rd_resp_data;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       bram_en_0, bram_wen_0, bram_en_1, bram_wen_1;
    logic [2:0] bram_addr_0, bram_addr_1;
    logic [7:0] bram_din_0, bram_din_1, bram_dout_0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bram_port_scheduler #(.Depth(DEPTH), .Width(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .init_start(init_start), .init_busy(init_busy), .clear_done(clear_done),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .bram_en_0(bram_en_0), .bram_wen_0(bram_wen_0), .bram_addr_0(bram_addr_0),
        .bram_din_0(bram_din_0), .bram_dout_0(bram_dout_0),
        .bram_en_1(bram_en_1), .bram_wen_1(bram_wen_1), .bram_addr_1(bram_addr_1),
        .bram_din_1(bram_din_1)
    );

    // Read-first dual-port memory the scheduler drives.
    logic [7:0] bram [DEPTH];
    always @(posedge clk) begin
        if (bram_en_0) begin
            bram_dout_0 <= bram[bram_addr_0];
            if (bram_wen_0) bram[bram_addr_0] <= bram_din_0;
        end
        if (bram_en_1 && bram_wen_1) bram[bram_addr_1] <= bram_din_1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory contents as the requesters should see them,
    // sweep progress, and whether the read lost the last collision.
    bit [7:0] ref_mem [DEPTH];
    bit       m_clear   = 1'b1;
    int       m_idx     = 0;
    bit       m_rd_lost = 1'b0;
    bit       m_rd_acc  = 1'b0;
    bit       m_wr_acc  = 1'b0;
    logic [7:0] exp_q [$];

    function automatic bit f_conf();
        return rd_valid && wr_valid && (rd_addr == wr_addr);
    endfunction
    function automatic bit f_rd_rdy();
        return !m_clear && !(f_conf() && !m_rd_lost);
    endfunction
    function automatic bit f_wr_rdy();
        return !m_clear && !(f_conf() && m_rd_lost);
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        bit rr, ww, cf;
        if (!rst_n) begin
            m_clear   = 1'b1;
            m_idx     = 0;
            m_rd_lost = 1'b0;
            m_rd_acc  = 1'b0;
            m_wr_acc  = 1'b0;
            exp_q.delete();
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        end else begin
            m_rd_acc = 1'b0;
            m_wr_acc = 1'b0;
            if (m_clear) begin
                if (m_idx == HALF - 1) m_clear = 1'b0;
                else m_idx++;
            end else begin
                rr = f_rd_rdy();
                ww = f_wr_rdy();
                cf = f_conf();
                if (rd_valid && rr) begin
                    exp_q.push_back(ref_mem[rd_addr]);
                    m_rd_acc = 1'b1;
                end
                if (wr_valid && ww) begin
                    ref_mem[wr_addr] = wr_data;
                    m_wr_acc = 1'b1;
                end
                m_rd_lost = cf && !rr;
                if (init_start) begin
                    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
                    m_clear = 1'b1;
                    m_idx   = 0;
                end
            end
        end
    end

    // Per-cycle control/port checks against the model.
    always @(negedge clk) begin
        check("init_busy", 32'(init_busy), 32'(m_clear));
        check("rd_ready", 32'(rd_ready), 32'(f_rd_rdy()));
        check("wr_ready", 32'(wr_ready), 32'(f_wr_rdy()));
        if (m_clear) begin
            check("clear_done", 32'(clear_done), 32'(m_idx == HALF - 1));
            check("clr_en", 32'({bram_en_0, bram_wen_0, bram_en_1, bram_wen_1}), 32'hF);
            check("clr_addr_0", 32'(bram_addr_0), 2 * m_idx);
            check("clr_addr_1", 32'(bram_addr_1), 2 * m_idx + 1);
            check("clr_din", 32'({bram_din_0, bram_din_1}), 0);
        end else begin
            check("clear_done_idle", 32'(clear_done), 0);
            check("en_0", 32'(bram_en_0), 32'(rd_valid && f_rd_rdy()));
            check("wen_0", 32'(bram_wen_0), 0);
            check("en_1", 32'(bram_en_1), 32'(wr_valid && f_wr_rdy()));
            check("wen_1", 32'(bram_wen_1), 32'(wr_valid && f_wr_rdy()));
            if (bram_en_0) check("addr_0", 32'(bram_addr_0), 32'(rd_addr));
            if (bram_en_1) begin
                check("addr_1", 32'(bram_addr_1), 32'(wr_addr));
                check("din_1", 32'(bram_din_1), 32'(wr_data));
            end
        end
    end

    // Response monitor: pops the scoreboard whenever a response is presented.
    always @(negedge clk) begin : monitor
        logic [7:0] e;
        if (rd_resp_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("rd_resp_data", 32'(rd_resp_data), 32'(e));
            end
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("missing_resp", 0, 1);
        end
    end

    // Issue a new request on each side only when that side is free.
    task automatic cycle_req(input bit rv, input logic [2:0] ra, input bit wv,
                             input logic [2:0] wa, input logic [7:0] wd, input bit is);
        if (!(rd_valid && !m_rd_acc)) begin
            rd_valid = rv;
            rd_addr  = ra;
        end
        if (!(wr_valid && !m_wr_acc)) begin
            wr_valid = wv;
            wr_addr  = wa;
            wr_data  = wd;
        end
        init_start = is;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (m_clear && n < 20) begin
            cycle_req(1'b0, 3'd0, 1'b0, 3'd0, 8'd0, 1'b0);
            n++;
        end
        if (m_clear) check(name, 1, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit rd_done;
        int waited;
        @(posedge clk);
        #1;
        check("rst_init_busy", 32'(init_busy), 1);
        check("rst_rd_ready", 32'(rd_ready), 0);
        check("rst_wr_ready", 32'(wr_ready), 0);
        check("rst_clear_done", 32'(clear_done), 0);
        check("rst_addr_1", 32'(bram_addr_1), 1);
        check("rst_resp_valid", 32'(rd_resp_valid), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        wait_idle("sweep_after_reset");

        // Write 3 then read all addresses.
        cycle_req(1'b0, 3'd0, 1'b1, 3'd3, 8'hA5, 1'b0);
        cycle_req(1'b1, 3'd3, 1'b0, 3'd0, 8'h00, 1'b0);
        for (int a = 0; a < DEPTH; a++)
            if (a != 3) cycle_req(1'b1, 3'(a), 1'b0, 3'd0, 8'h00, 1'b0);
        cycle_req(1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0);

        // Same-address collision: write first, read next cycle.
        rd_valid = 1'b1; rd_addr = 3'd5;
        wr_valid = 1'b1; wr_addr = 3'd5; wr_data = 8'h3C;
        #1;
        check("s3_wr_ready", 32'(wr_ready), 1);
        check("s3_rd_ready", 32'(rd_ready), 0);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        #1;
        check("s3_rd_ready_next", 32'(rd_ready), 1);
        cycle_req(1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0);
        cycle_req(1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0);

        // Persistent writer on addr 2 against one pending read.
        rd_done = 1'b0;
        waited  = 0;
        for (int i = 0; i < 8; i++) begin
            cycle_req(i == 1, 3'd2, 1'b1, 3'd2, 8'(8'h40 + i), 1'b0);
            if (i >= 1 && !rd_done) begin
                waited++;
                if (m_rd_acc) rd_done = 1'b1;
            end
        end
        check("s4_read_granted", 32'(rd_done), 1);
        check("s4_read_wait", 32'(waited <= 2), 1);
        cycle_req(1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0);
        cycle_req(1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0);

        // init_start alongside a write and a read; second pulse mid-sweep.
        cycle_req(1'b1, 3'd3, 1'b1, 3'd6, 8'h11, 1'b1);
        check("s5_wr_taken", 32'(m_wr_acc), 1);
        cycle_req(1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0);
        cycle_req(1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b1);
        wait_idle("sweep_after_init");
        cycle_req(1'b1, 3'd6, 1'b0, 3'd0, 8'h00, 1'b0);
        cycle_req(1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0);

        // Asynchronous reset in the middle of a sweep.
        cycle_req(1'b0, 3'd0, 1'b1, 3'd1, 8'h77, 1'b1);
        cycle_req(1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0);
        cycle_req(1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0);
        check("s6_addr0_mid", 32'(bram_addr_0), 4);
        #2 rst_n = 1'b0;
        #1;
        check("s6_busy", 32'(init_busy), 1);
        check("s6_addr_0", 32'(bram_addr_0), 0);
        check("s6_addr_1", 32'(bram_addr_1), 1);
        check("s6_en", 32'({bram_en_0, bram_wen_0, bram_en_1, bram_wen_1}), 32'hF);
        check("s6_ready", 32'({rd_ready, wr_ready}), 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        wait_idle("sweep_after_async_reset");

        // Randomised traffic on a small address space to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            cycle_req($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
                      $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
                      8'($urandom), $urandom_range(0, 39) == 0);
        end
        for (int i = 0; i < 8; i++) cycle_req(1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
